// File: rtl/alu_req_arbiter_if.sv
// Handshake bundle between the two operand requesters, the shared ALU and the
// response consumer on one side, and the arbiter/sequencer on the other.
interface alu_req_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic        req1_valid;
  logic        req1_ready;
  logic        sel;
  logic        op_start;
  logic [31:0] res_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        busy;

  modport master (
    input  req0_valid, req1_valid, res_data, rsp_ready,
    output req0_ready, req1_ready, sel, op_start,
    output rsp_valid, rsp_id, rsp_data, busy
  );

  modport slave (
    output req0_valid, req1_valid, res_data, rsp_ready,
    input  req0_ready, req1_ready, sel, op_start,
    input  rsp_valid, rsp_id, rsp_data, busy
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter/sequencer sharing one 32-bit ALU between two requesters:
// grant, start pulse, fixed-latency wait, then a tagged response.
module alu_req_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic               clk,
  input  logic               rst,
  alu_req_arbiter_if.master  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        prio_q, prio_d;
  logic        sel_q, sel_d;
  logic        op_start_q, op_start_d;
  logic        req0_ready_q, req0_ready_d;
  logic        req1_ready_q, req1_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_id_q, rsp_id_d;
  logic [31:0] rsp_data_q, rsp_data_d;
  logic        busy_q, busy_d;

  // Every output is computed one cycle ahead so it can come straight from a flop.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prio_d       = prio_q;
    sel_d        = sel_q;
    op_start_d   = 1'b0;
    req0_ready_d = 1'b0;
    req1_ready_d = 1'b0;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (bus.req0_valid || bus.req1_valid) begin
          sel_d      = (bus.req0_valid && bus.req1_valid) ? prio_q : bus.req1_valid;
          op_start_d = 1'b1;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d   = bus.res_data;
          rsp_id_d     = sel_q;
          rsp_valid_d  = 1'b1;
          req0_ready_d = ~sel_q;
          req1_ready_d = sel_q;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          prio_d      = ~rsp_id_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      prio_q       <= 1'b0;
      sel_q        <= 1'b0;
      op_start_q   <= 1'b0;
      req0_ready_q <= 1'b0;
      req1_ready_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= 32'd0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      prio_q       <= prio_d;
      sel_q        <= sel_d;
      op_start_q   <= op_start_d;
      req0_ready_q <= req0_ready_d;
      req1_ready_q <= req1_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      busy_q       <= busy_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.op_start   = op_start_q;
  assign bus.req0_ready = req0_ready_q;
  assign bus.req1_ready = req1_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Scoreboard bench: instance A (EXEC_CYCLES=1) and instance B (EXEC_CYCLES=4),
// each with its own expected-response queue and monitor.
module tb_alu_req_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   total  = 0;
  int   passed = 0;
  exp_t qa[$];
  exp_t qb[$];

  alu_req_arbiter_if ifa();
  alu_req_arbiter_if ifb();

  alu_req_arbiter #(.EXEC_CYCLES(1)) dut_a (.clk(clk), .rst(rst_a), .bus(ifa));
  alu_req_arbiter #(.EXEC_CYCLES(4)) dut_b (.clk(clk), .rst(rst_b), .bus(ifb));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input bit b, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(b ? ifb.op_start : ifa.op_start) && n < 40);
    if (!(b ? ifb.op_start : ifa.op_start)) begin
      total++;
      $display("FAIL %s_start_timeout: got no OP_START, required one within 40 cycles", b ? "B" : "A");
    end
  endtask

  task automatic wait_rsp(input bit b);
    int n = 0;
    while (!(b ? ifb.rsp_valid : ifa.rsp_valid) && n < 40) begin
      tick();
      n++;
    end
    if (!(b ? ifb.rsp_valid : ifa.rsp_valid)) begin
      total++;
      $display("FAIL %s_rsp_timeout: got no RSP_VALID, required one within 40 cycles", b ? "B" : "A");
    end
  endtask

  // Monitors: compare each new response against the head of its queue.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ifa.rsp_valid && !prev) begin
        if (qa.size() == 0) begin
          total++;
          $display("FAIL A_unexpected_rsp: got id=%0d data=%h, required no response", ifa.rsp_id, ifa.rsp_data);
        end else begin
          check("A_rsp_id", 32'(ifa.rsp_id), 32'(qa[0].id));
          check("A_rsp_data", ifa.rsp_data, qa[0].data);
          check("A_ready_pulse", 32'({ifa.req1_ready, ifa.req0_ready}), qa[0].id ? 32'd2 : 32'd1);
          $display("A rsp id=%0d data=%h", ifa.rsp_id, ifa.rsp_data);
          void'(qa.pop_front());
        end
      end
      prev = ifa.rsp_valid;
    end
  end

  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (ifb.rsp_valid && !prev) begin
        if (qb.size() == 0) begin
          total++;
          $display("FAIL B_unexpected_rsp: got id=%0d data=%h, required no response", ifb.rsp_id, ifb.rsp_data);
        end else begin
          check("B_rsp_id", 32'(ifb.rsp_id), 32'(qb[0].id));
          check("B_rsp_data", ifb.rsp_data, qb[0].data);
          check("B_ready_pulse", 32'({ifb.req1_ready, ifb.req0_ready}), qb[0].id ? 32'd2 : 32'd1);
          $display("B rsp id=%0d data=%h", ifb.rsp_id, ifb.rsp_data);
          void'(qb.pop_front());
        end
      end
      prev = ifb.rsp_valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.req0_valid = 0; ifa.req1_valid = 0; ifa.rsp_ready = 0; ifa.res_data = 32'd0;
    ifb.req0_valid = 0; ifb.req1_valid = 0; ifb.rsp_ready = 0; ifb.res_data = 32'd0;
    repeat (2) tick();
    check("A_reset_ctrl", 32'({ifa.sel, ifa.op_start, ifa.req0_ready, ifa.req1_ready,
                              ifa.rsp_valid, ifa.rsp_id, ifa.busy}), 32'd0);
    check("A_reset_data", ifa.rsp_data, 32'd0);
    check("B_reset_ctrl", 32'({ifb.sel, ifb.op_start, ifb.req0_ready, ifb.req1_ready,
                              ifb.rsp_valid, ifb.rsp_id, ifb.busy}), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // Single request from 0, EXEC_CYCLES=1
    ifa.req0_valid = 1; ifa.rsp_ready = 1; ifa.res_data = 32'hDEADBEEF;
    qa.push_back('{1'b0, 32'hDEADBEEF});
    tick();
    check("A_c1_op_start", 32'(ifa.op_start), 32'd1);
    check("A_c1_sel", 32'(ifa.sel), 32'd0);
    check("A_c1_busy", 32'(ifa.busy), 32'd1);
    tick();
    check("A_c2_op_start", 32'(ifa.op_start), 32'd0);
    check("A_c2_rsp_valid", 32'(ifa.rsp_valid), 32'd0);
    tick();
    check("A_c3_rsp_valid", 32'(ifa.rsp_valid), 32'd1);
    ifa.req0_valid = 0;
    tick();
    check("A_c4_idle", 32'({ifa.busy, ifa.rsp_valid, ifa.req0_ready}), 32'd0);

    // Fresh PRIO, both requesters held high: grants 0,1,0,1 every 4 cycles
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    ifa.req0_valid = 1; ifa.req1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      wait_start(1'b0, n);
      check($sformatf("A_rr_sel%0d", i), 32'(ifa.sel), 32'(i % 2));
      if (i > 0) check($sformatf("A_rr_spacing%0d", i), 32'(n), 32'd4);
      ifa.res_data = 32'hA0000000 + 32'(i);
      qa.push_back('{1'(i % 2), 32'hA0000000 + 32'(i)});
    end
    wait_rsp(1'b0);
    ifa.req0_valid = 0; ifa.req1_valid = 0;
    repeat (2) tick();

    // EXEC_CYCLES=4, requester 1 only, response held off for 5 cycles
    ifb.req1_valid = 1; ifb.rsp_ready = 0;
    tick();
    check("B_c1_op_start", 32'(ifb.op_start), 32'd1);
    check("B_c1_sel", 32'(ifb.sel), 32'd1);
    qb.push_back('{1'b1, 32'h12345678});
    ifb.res_data = 32'h0BADF00D;
    tick();
    check("B_c2_op_start", 32'(ifb.op_start), 32'd0);
    repeat (3) tick();
    ifb.res_data = 32'h12345678;
    check("B_c5_rsp_valid", 32'(ifb.rsp_valid), 32'd0);
    tick();
    ifb.res_data = 32'hFFFFFFFF;
    ifb.req1_valid = 0;
    ifb.req0_valid = 1;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("B_hold%0d_valid", k), 32'(ifb.rsp_valid), 32'd1);
      check($sformatf("B_hold%0d_data", k), ifb.rsp_data, 32'h12345678);
      check($sformatf("B_hold%0d_id", k), 32'(ifb.rsp_id), 32'd1);
      check($sformatf("B_hold%0d_ready", k), 32'({ifb.req1_ready, ifb.req0_ready}), (k == 0) ? 32'd2 : 32'd0);
      check($sformatf("B_hold%0d_nogrant", k), 32'({ifb.op_start, ifb.sel}), 32'd1);
      if (k == 4) ifb.rsp_ready = 1;
      tick();
    end
    check("B_idle_after_hold", 32'({ifb.busy, ifb.rsp_valid, ifb.op_start}), 32'd0);
    tick();
    check("B_req0_grant", 32'({ifb.op_start, ifb.sel}), 32'd2);
    qb.push_back('{1'b0, 32'hFFFFFFFF});
    wait_rsp(1'b1);
    ifb.req0_valid = 0;
    repeat (2) tick();

    // Reset during WAIT abandons the transaction and clears PRIO (now 1)
    ifb.req1_valid = 1;
    wait_start(1'b1, n);
    check("B_pre_rst_sel", 32'(ifb.sel), 32'd1);
    tick();
    rst_b = 1'b1;
    #1;
    check("B_async_rst_ctrl", 32'({ifb.sel, ifb.op_start, ifb.req0_ready, ifb.req1_ready,
                                  ifb.rsp_valid, ifb.rsp_id, ifb.busy}), 32'd0);
    check("B_async_rst_data", ifb.rsp_data, 32'd0);
    ifb.req1_valid = 0;
    repeat (3) tick();
    ifb.req0_valid = 1; ifb.req1_valid = 1;
    rst_b = 1'b0;
    wait_start(1'b1, n);
    check("B_post_rst_sel", 32'(ifb.sel), 32'd0);
    ifb.res_data = 32'hCAFE0001;
    qb.push_back('{1'b0, 32'hCAFE0001});
    wait_rsp(1'b1);
    ifb.req0_valid = 0; ifb.req1_valid = 0;
    repeat (3) tick();

    check("A_queue_empty", 32'(qa.size()), 32'd0);
    check("B_queue_empty", 32'(qb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_req_arbiter.md
# alu_req_arbiter

Round-robin arbiter and sequencer that shares one 32-bit ALU datapath between two requesters. It drives the select line of the 32-bit 2:1 operand mux in front of the ALU, issues a start pulse, and waits a fixed execution latency. It then captures the ALU result and returns it on a response channel tagged with the requester ID. It sits between the two operand sources and the shared ALU in the alu32 server.

## Interface
- EXEC_CYCLES, 1: ALU latency in cycles from OP_START to valid RES_DATA; legal range 1..15.
- CLK  in  1  single clock, all state updates on rising edge
- RST  in  1  asynchronous, active-high reset
- REQ0_VALID  in  1  requester 0 has an operand on mux input D0
- REQ0_READY  out  1  one-cycle pulse: requester 0 transaction completed
- REQ1_VALID  in  1  requester 1 has an operand on mux input D1
- REQ1_READY  out  1  one-cycle pulse: requester 1 transaction completed
- SEL  out  1  operand mux select (0 = D0/requester 0, 1 = D1/requester 1)
- OP_START  out  1  one-cycle start pulse to ALU
- RES_DATA  in  32  ALU result
- RSP_VALID  out  1  response available
- RSP_READY  in  1  response consumer accepts
- RSP_ID  out  1  requester ID of current response
- RSP_DATA  out  32  captured ALU result
- BUSY  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP. Reset state IDLE.
- Priority register PRIO (reset 0). Arbitration in IDLE: only one VALID high -> that requester wins; both high -> requester PRIO wins; none -> stay IDLE.
- IDLE -> ISSUE on any VALID. Winner registered into SEL on that edge.
- ISSUE (1 cycle): OP_START=1. Counter loaded with EXEC_CYCLES-1. -> WAIT.
- WAIT: counter decrements each cycle. When counter == 0, RES_DATA sampled into RSP_DATA, SEL copied into RSP_ID. -> RESP.
- RESP: RSP_VALID=1. REQn_READY (n = RSP_ID) high for the first RESP cycle only. Stay until RSP_READY=1. On the edge with RSP_READY=1: -> IDLE, PRIO <= ~RSP_ID.
- SEL held constant from ISSUE through RESP and retains its last value in IDLE. The requester must hold its operand and VALID until its READY pulse.
- VALID dropped mid-transaction is a protocol violation. The block completes the transaction and still pulses READY.
- VALID of the non-granted requester is ignored until the next IDLE.
- Reset asserted in any state: immediate return to IDLE and abandonment of any in-flight transaction. No READY or RSP_VALID is produced for the abandoned transaction.
- Reset values: SEL=0, OP_START=0, REQ0_READY=0, REQ1_READY=0, RSP_VALID=0, RSP_ID=0, RSP_DATA=0, BUSY=0, PRIO=0.
- All outputs are registered or decoded from state registers only. There is no combinational path from any input to any output.

## Timing
- VALID sampled high in IDLE on edge E0: ISSUE during cycle 1 (OP_START=1, SEL valid).
- WAIT occupies cycles 2..1+EXEC_CYCLES.
- RES_DATA is sampled on the edge ending cycle 1+EXEC_CYCLES.
- RSP_VALID and the READY pulse rise in cycle 2+EXEC_CYCLES.
- With RSP_READY tied high, one transaction takes EXEC_CYCLES+3 cycles including the IDLE cycle. Back-to-back transactions from alternating requesters therefore start every EXEC_CYCLES+3 cycles.
- RSP_DATA and RSP_ID are stable while RSP_VALID=1.

## Test plan
- Reset, then REQ0_VALID=1 only, EXEC_CYCLES=1, RES_DATA=0xDEADBEEF -> SEL=0; OP_START in cycle 1; RSP_VALID, RSP_ID=0, RSP_DATA=0xDEADBEEF and REQ0_READY pulse in cycle 3.
- Both VALID held high continuously, RSP_READY=1 -> grants alternate 0,1,0,1; each RSP_ID matches the SEL of that transaction; READY pulses alternate accordingly.
- EXEC_CYCLES=4, REQ1 only -> OP_START in cycle 1; RES_DATA changed to 0x12345678 in cycle 5 and 0xFFFFFFFF in cycle 6 -> RSP_DATA=0x12345678, RSP_VALID in cycle 6.
- RSP_READY held low for 5 cycles in RESP -> RSP_VALID/RSP_DATA stable for all 5 cycles; READY pulse only in the first; a REQ0_VALID raised during this time is not granted until after IDLE.
- RST pulsed during WAIT -> all outputs 0 asynchronously; no READY/RSP_VALID for that transaction; PRIO=0, so with both VALID high after reset, requester 0 is granted.
